// File: rtl/conv_window_sequencer_pkg.sv
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants, state encoding and tap-offset helper for the
//               3x3 padded-window fetch sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int IMG_W  = 64;
    localparam int PAD_W  = IMG_W + 2;
    localparam int DATA_W = 20;
    localparam int TAPS   = 9;
    localparam int ADDR_W = 13;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Offset of tap k = dy*3+dx from the window's top-left padded address.
    function automatic logic [ADDR_W-1:0] tap_offset(input logic [3:0] tap);
        logic [ADDR_W-1:0] off;
        case (tap)
            4'd0:    off = ADDR_W'(0);
            4'd1:    off = ADDR_W'(1);
            4'd2:    off = ADDR_W'(2);
            4'd3:    off = ADDR_W'(PAD_W);
            4'd4:    off = ADDR_W'(PAD_W + 1);
            4'd5:    off = ADDR_W'(PAD_W + 2);
            4'd6:    off = ADDR_W'(2 * PAD_W);
            4'd7:    off = ADDR_W'(2 * PAD_W + 1);
            4'd8:    off = ADDR_W'(2 * PAD_W + 2);
            default: off = ADDR_W'(0);
        endcase
        return off;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_window_sequencer_pad_addr_gen.sv
// ============================================================================
// Module      : pad_addr_gen
// Description : Tracks the padded-space row base and column of the current
//               window and forms pseudo_addr for the selected tap.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pad_addr_gen
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic [3:0]        tap_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic [5:0] COL_LAST = 6'(IMG_W - 1);

    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [5:0]        col_q, col_d;

    always_comb begin
        row_base_d = row_base_q;
        col_d      = col_q;
        if (clr_i) begin
            row_base_d = '0;
            col_d      = '0;
        end else if (adv_i) begin
            // Row base steps by the padded pitch, so no multiplier is needed.
            if (col_q == COL_LAST) begin
                col_d      = '0;
                row_base_d = row_base_q + ADDR_W'(PAD_W);
            end else begin
                col_d = col_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_base_q <= '0;
            col_q      <= '0;
        end else begin
            row_base_q <= row_base_d;
            col_q      <= col_d;
        end
    end

    assign addr_o = row_base_q + ADDR_W'(col_q) + tap_offset(tap_i);

endmodule

`default_nettype wire

// File: rtl/conv_window_sequencer.sv
// ============================================================================
// Module      : conv_window_sequencer
// Description : Walks a 64x64 image, fetches each zero-padded 3x3 window tap by
//               tap and presents the window downstream with valid/ready.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int FETCH_LAT = 2
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      pseudo_addr,
    input  logic [DATA_W-1:0]      data,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [TAPS*DATA_W-1:0] win_data,
    output logic [5:0]             win_x,
    output logic [5:0]             win_y
);

    localparam int              WAIT_W    = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_LAT - 1);
    localparam logic [5:0]      XY_LAST   = 6'(IMG_W - 1);
    localparam logic [3:0]      TAP_LAST  = 4'(TAPS - 1);

    state_e                   state_q, state_d;
    logic [WAIT_W-1:0]        wcnt_q, wcnt_d;
    logic [3:0]               tap_q, tap_d;
    logic [5:0]               x_q, x_d;
    logic [5:0]               y_q, y_d;
    logic [TAPS*DATA_W-1:0]   win_q, win_d;
    logic                     pad_clr;
    logic                     pad_adv;

    pad_addr_gen u_pad_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (pad_clr),
        .adv_i  (pad_adv),
        .tap_i  (tap_q),
        .addr_o (pseudo_addr)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tap_d   = tap_q;
        x_d     = x_q;
        y_d     = y_q;
        win_d   = win_q;
        pad_clr = 1'b0;
        pad_adv = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    wcnt_d  = '0;
                    tap_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    pad_clr = 1'b1;
                end
            end
            FETCH: begin
                if (wcnt_q == WAIT_LAST) begin
                    for (int k = 0; k < TAPS; k++) begin
                        if (tap_q == 4'(k)) begin
                            win_d[k*DATA_W +: DATA_W] = data;
                        end
                    end
                    wcnt_d = '0;
                    // Tap stays at 8 while presenting so pseudo_addr holds.
                    if (tap_q == TAP_LAST) begin
                        state_d = PRESENT;
                    end else begin
                        tap_d = tap_q + 4'd1;
                    end
                end else begin
                    wcnt_d = wcnt_q + WAIT_W'(1);
                end
            end
            PRESENT: begin
                if (win_ready) begin
                    tap_d  = '0;
                    wcnt_d = '0;
                    x_d    = x_q + 6'd1;
                    if (x_q == XY_LAST) begin
                        y_d = y_q + 6'd1;
                    end
                    if ((x_q == XY_LAST) && (y_q == XY_LAST)) begin
                        state_d = DONE;
                        pad_clr = 1'b1;
                    end else begin
                        state_d = FETCH;
                        pad_adv = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            tap_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tap_q   <= tap_d;
            x_q     <= x_d;
            y_q     <= y_d;
            win_q   <= win_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign win_valid = (state_q == PRESENT);
    assign win_data  = win_q;
    assign win_x     = x_q;
    assign win_y     = y_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_sequencer.sv
// ============================================================================
// Module      : tb_conv_window_sequencer
// Description : Scoreboard bench with a padded-memory model (pixel = index+1).
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv_window_sequencer;

    localparam int DW = 20;
    localparam int WW = 9 * DW;
    localparam int WIN_CYC = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          win_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          win_valid;
    logic [12:0]   pseudo_addr;
    logic [DW-1:0] data;
    logic [WW-1:0] win_data;
    logic [5:0]    win_x;
    logic [5:0]    win_y;
    logic [12:0]   iaddr_q = '0;
    longint        cyc = 0;

    typedef struct {
        logic [5:0]    x;
        logic [5:0]    y;
        logic [WW-1:0] d;
    } win_t;

    win_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_count = 0;
    int   stall_count = 0;
    int   done_count = 0;

    conv_window_sequencer #(.FETCH_LAT(2)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .pseudo_addr (pseudo_addr),
        .data        (data),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_data    (win_data),
        .win_x       (win_x),
        .win_y       (win_y)
    );

    always #5 clk = ~clk;

    // Zero-padding block: registered address, combinational memory read.
    function automatic int pix(input int a);
        int r;
        int c;
        r = a / 66;
        c = a % 66;
        if (r >= 1 && r <= 64 && c >= 1 && c <= 64) return (r - 1) * 64 + (c - 1) + 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        iaddr_q <= pseudo_addr;
    end

    assign data = DW'(pix(int'(iaddr_q)));

    function automatic logic [WW-1:0] pack9(input int t [9]);
        logic [WW-1:0] d;
        d = '0;
        for (int k = 0; k < 9; k++) d[k*DW +: DW] = DW'(t[k]);
        return d;
    endfunction

    function automatic logic [WW-1:0] model_win(input int x, input int y);
        logic [WW-1:0] d;
        d = '0;
        for (int k = 0; k < 9; k++) d[k*DW +: DW] = DW'(pix((y + k / 3) * 66 + x + k % 3));
        return d;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_win(input int x, input int y, input logic [WW-1:0] d);
        win_t e;
        e.x = 6'(x);
        e.y = 6'(y);
        e.d = d;
        sb_q.push_back(e);
    endtask

    task automatic push_scan(input int count);
        int hv0 [9];
        int hvl [9];
        hv0 = '{0, 0, 0, 0, 1, 2, 0, 65, 66};
        hvl = '{4031, 4032, 0, 4095, 4096, 0, 0, 0, 0};
        for (int i = 0; i < count; i++) begin
            if (i == 0)         push_win(0, 0, pack9(hv0));
            else if (i == 4095) push_win(63, 63, pack9(hvl));
            else                push_win(i % 64, i / 64, model_win(i % 64, i / 64));
        end
    endtask

    // Monitor: pops the scoreboard on every handshake.
    initial begin
        win_t e;
        forever begin
            @(negedge clk);
            if (done) done_count++;
            if (win_valid && !win_ready) stall_count++;
            if (win_valid && win_ready) begin
                hs_count++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL window_unexpected: got (%0d,%0d) with no window expected", win_x, win_y);
                end else begin
                    e = sb_q.pop_front();
                    if (win_x !== e.x || win_y !== e.y || win_data !== e.d) begin
                        errors++;
                        $display("FAIL window: got (%0d,%0d) %h, expected (%0d,%0d) %h",
                                 win_x, win_y, win_data, e.x, e.y, e.d);
                    end
                end
            end
        end
    end

    initial begin
        int            seq [9];
        int            n;
        int            hs_before;
        logic [WW-1:0] d0;
        logic [12:0]   a0;
        bit            stable;
        longint        t0;
        longint        t1;

        seq = '{0, 1, 2, 66, 67, 68, 132, 133, 134};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", win_valid, 0);
        check("rst_addr", pseudo_addr, 0);
        check("rst_win_data_nonzero", longint'(win_data != '0), 0);
        check("rst_win_x", win_x, 0);
        check("rst_win_y", win_y, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full scan with a restart attempt and a backpressure episode
        push_scan(4096);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        check("busy_after_start", busy, 1);
        for (int i = 0; i < 18; i++) begin
            check($sformatf("first_addr_%0d", i), pseudo_addr, seq[i / 2]);
            @(posedge clk); #1;
        end

        n = 0;
        while (!(win_x == 6'd10 && win_y == 6'd0) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check("reach_10_0", longint'(n < 2000), 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("no_restart_x", win_x, 10);
        check("no_restart_busy", busy, 1);

        n = 0;
        while (!(win_x == 6'd5 && win_y == 6'd3) && n < 6000) begin
            @(posedge clk); #1; n++;
        end
        check("reach_5_3", longint'(n < 6000), 1);
        win_ready = 1'b0;
        n = 0;
        while (!win_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("bp_valid_rises", win_valid, 1);
        d0 = win_data;
        a0 = pseudo_addr;
        check("bp_hold_addr", a0, 337);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (!win_valid || win_data !== d0 || pseudo_addr !== a0) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        win_ready = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!win_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("after_bp_x", win_x, 6);
        check("after_bp_y", win_y, 3);

        n = 0;
        while (!done && n < 90000) begin
            @(posedge clk); #1; n++;
        end
        check("done_seen", done, 1);
        t1 = cyc;
        check("scan_cycles_in_range",
              longint'((t1 - t0 - stall_count) >= 4096 * WIN_CYC - 1 &&
                       (t1 - t0 - stall_count) <= 4096 * WIN_CYC + 3), 1);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("busy_falls", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_count", done_count, 1);
        check("handshakes", hs_count, 4096);
        check("scoreboard_empty_1", sb_q.size(), 0);

        // Second scan aborted by reset during FETCH of window (20,7)
        push_scan(7 * 64 + 20);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(win_x == 6'd20 && win_y == 6'd7) && n < 12000) begin
            @(posedge clk); #1; n++;
        end
        check("reach_20_7", longint'(n < 12000), 1);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_valid", win_valid, 0);
        check("abort_addr", pseudo_addr, 0);
        check("abort_win_data_nonzero", longint'(win_data != '0), 0);
        check("abort_win_x", win_x, 0);
        check("abort_win_y", win_y, 0);
        check("abort_scoreboard_empty", sb_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_no_done", done_count, 1);

        // Restart after abort: first window must be (0,0) again
        hs_before = hs_count;
        push_scan(1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (hs_count == hs_before && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("restart_window_seen", longint'(hs_count - hs_before), 1);
        check("scoreboard_empty_2", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
